seq_multiply: RTL and testbench

- Iterative shift-add 64-bit integer multiplier; the multiply counterpart to the combinational `divide` unit in the processing unit's execute stage.
- Shares the `divide` operand and flag convention: `in1`, `in2`, 2-bit `flag`, 64-bit `out`.
- Adds valid/ready handshakes on both sides, so the execute stage can stall on a multi-cycle result.

---
 rtl/mul_pkg.sv | 36 +++
 rtl/mul_operand_cond.sv | 29 ++
 rtl/seq_multiply.sv | 123 ++++++++++++
 tb/tb_seq_multiply.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the execute-stage multiply unit: flag encodings (common with the
// divide unit), FSM state encoding and the default datapath width.
package mul_pkg;

    // Operand/result width shared with the divide unit.
    localparam int unsigned DEFAULT_WIDTH = 64;

    // Operation select, same encoding slot as the divide unit's flag input.
    localparam logic [1:0] FLAG_MUL    = 2'd0;  // low half, unsigned
    localparam logic [1:0] FLAG_MULH   = 2'd1;  // high half, signed x signed
    localparam logic [1:0] FLAG_MULHU  = 2'd2;  // high half, unsigned x unsigned
    localparam logic [1:0] FLAG_MULHSU = 2'd3;  // high half, signed in1 x unsigned in2

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    // in1 is treated as signed for MULH and MULHSU.
    function automatic logic flag_in1_signed(input logic [1:0] f);
        return (f == FLAG_MULH) || (f == FLAG_MULHSU);
    endfunction

    // in2 is treated as signed only for MULH.
    function automatic logic flag_in2_signed(input logic [1:0] f);
        return (f == FLAG_MULH);
    endfunction

    // Every operation except MUL returns the upper half of the product.
    function automatic logic flag_high_half(input logic [1:0] f);
        return (f != FLAG_MUL);
    endfunction

endpackage

// File: rtl/mul_operand_cond.sv
// Operand conditioning for seq_multiply: converts both operands to unsigned magnitudes and
// computes the sign of the final product, according to the operation flag.
// The most negative value maps to its unsigned magnitude (2^(WIDTH-1)) without overflow.
module mul_operand_cond
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       flag,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] mag1,
    output logic [WIDTH-1:0] mag2,
    output logic             res_neg
);

    logic neg1;
    logic neg2;

    // An operand is negative only if the flag treats it as signed and its MSB is set.
    always_comb begin
        neg1    = flag_in1_signed(flag) & in1[WIDTH-1];
        neg2    = flag_in2_signed(flag) & in2[WIDTH-1];
        mag1    = neg1 ? ('0 - in1) : in1;
        mag2    = neg2 ? ('0 - in2) : in2;
        res_neg = neg1 ^ neg2;
    end

endmodule

// File: rtl/seq_multiply.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// One multiplier bit is consumed per BUSY cycle; a FIX cycle applies the result sign and
// selects the requested half; the result is held in DONE until the consumer takes it.
// Optional build macro SEQ_MULTIPLY_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits are all zero (at least one BUSY cycle). Results are unchanged.
module seq_multiply
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e         state;
    logic [1:0]         flag_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] mcand;   // multiplicand, pre-shifted by the iteration count
    logic [WIDTH-1:0]   mplier;  // multiplier, LSB is the bit consumed this cycle
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               res_neg;

    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   result;
    logic               busy_last;

    mul_operand_cond #(
        .WIDTH (WIDTH)
    ) u_operand_cond (
        .flag    (flag),
        .in1     (in1),
        .in2     (in2),
        .mag1    (mag1),
        .mag2    (mag2),
        .res_neg (res_neg)
    );

    // Datapath: conditional add, sign fix-up, half select and BUSY exit condition.
    always_comb begin
        acc_sum  = mplier[0] ? (acc + mcand) : acc;
        prod_fix = neg_q ? ('0 - acc) : acc;
        result   = flag_high_half(flag_q) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
`ifdef SEQ_MULTIPLY_EARLY_TERM_EN
        // Remaining multiplier bits after this shift are zero, so no more adds can happen.
        busy_last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_LAST);
`else
        busy_last = (cnt == CNT_LAST);
`endif
    end

    // Control FSM and all registered state/outputs; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            flag_q    <= FLAG_MUL;
            neg_q     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        flag_q   <= flag;
                        neg_q    <= res_neg;
                        mcand    <= {{WIDTH{1'b0}}, mag1};
                        mplier   <= mag2;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (busy_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // out keeps its value after the handshake.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiply.sv
// Directed self-checking bench for seq_multiply: reset values, all four operations,
// signed boundaries, result latency, output backpressure and reset in the middle of an op.
module tb_seq_multiply;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   flag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_multiply #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .flag      (flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    // Expected accept-to-out_valid latency for the current build.
    function automatic int lat(input int full, input int early);
`ifdef SEQ_MULTIPLY_EARLY_TERM_EN
        return early;
`else
        return full;
`endif
    endfunction

    // Run one operation from IDLE; hold out_ready low for 'hold' cycles once the result is up,
    // poking a stray in_valid meanwhile. Inputs change at #1 after a rising edge.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat,
                          input int hold);
        int n;
        flag     = f;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operand changes after acceptance must not matter.
        in1      = 64'h1234_5678_9ABC_DEF0;
        in2      = 64'h0FED_CBA9_8765_4321;
        flag     = ~f;
        check({tag, " in_ready_busy"}, W'(in_ready), W'(0));
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            if (!out_valid) n++;
        end
        if (!out_valid) begin
            check({tag, " timeout"}, W'(out_valid), W'(1));
        end else begin
            check({tag, " latency"}, W'(n), W'(exp_lat));
            check({tag, " out"}, out, exp);
            for (int i = 0; i < hold; i++) begin
                in_valid = (i >= 3 && i < 6);
                in1      = 64'd1;
                in2      = 64'd1;
                @(posedge clk);
                #1;
                check({tag, " hold_out"}, out, exp);
                check({tag, " hold_valid"}, W'(out_valid), W'(1));
                check({tag, " hold_in_ready"}, W'(in_ready), W'(0));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, " drain_valid"}, W'(out_valid), W'(0));
            check({tag, " drain_in_ready"}, W'(in_ready), W'(1));
            check({tag, " out_kept"}, out, exp);
            if (hold > 0) begin
                // The stray request during DONE must not have started anything.
                @(posedge clk);
                #1;
                check({tag, " idle_stays"}, W'(in_ready), W'(1));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        flag      = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", W'(in_ready), W'(1));
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst out", out, W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_10x5", 2'd0, 64'd10, 64'd5, 64'h0000_0000_0000_0032, lat(65, 4), 0);
        run_op("mulh_20xm7", 2'd1, 64'd20, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFFF, lat(65, 4), 0);
        run_op("mul_20xm7", 2'd0, 64'd20, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FF74, lat(65, 65), 0);
        run_op("mulhu_max", 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, lat(65, 65), 0);
        run_op("mulhsu_m1x2", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, lat(65, 3), 0);
        run_op("mul_zero_a", 2'd0, 64'd0, 64'd123, 64'd0, lat(65, 8), 0);
        run_op("mulh_zero_b", 2'd1, 64'hFFFF_FFFF_FFFF_FF85, 64'd0, 64'd0, lat(65, 2), 0);
        run_op("mulh_min_min", 2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, lat(65, 65), 0);
        run_op("mulh_min_m1", 2'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_0000_0000, lat(65, 2), 0);
        run_op("mul_min_m1", 2'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, lat(65, 65), 0);
        run_op("mulhsu_min_2p63", 2'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'hC000_0000_0000_0000, lat(65, 65), 0);
        run_op("mul_7x5", 2'd0, 64'd7, 64'd5, 64'd35, lat(65, 4), 0);

        // Backpressure: result held for 10 cycles with a stray request in the middle.
        run_op("bp_5x6", 2'd0, 64'd5, 64'd6, 64'd30, lat(65, 4), 10);

        // Reset at BUSY iteration 30; the multiplier keeps early termination from finishing.
        flag     = 2'd0;
        in1      = 64'd9;
        in2      = 64'h8000_0000_0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("midrst busy", W'(in_ready), W'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst out_valid", W'(out_valid), W'(0));
        check("midrst out", out, W'(0));
        check("midrst in_ready", W'(in_ready), W'(1));
        run_op("post_rst_3x4", 2'd0, 64'd3, 64'd4, 64'd12, lat(65, 4), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
